// File: rtl/alu_exec_mc.sv
// alu_exec_mc - multi-cycle ALU execution unit for the EX stage.
//
// Single-cycle ops (and, or, add, sub, slt) register their result at the
// accept edge and pulse done_o in the following cycle. Multiply runs as an
// iterative shift-add over DATA_W cycles while busy_o is high.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     op request, sampled only while idle
//   ctrl_i      ALU control code (and/or/add/sub/slt/mul)
//   src1_i      operand A
//   src2_i      operand B
//   result_o    registered result, held until the next completion
//   zero_o      completed result == 0
//   overflow_o  signed overflow of add/sub, 0 otherwise
//   err_o       completed op used an unsupported control code
//   busy_o      multiply in progress
//   done_o      one-cycle pulse when result/flags update
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start_i; single-cycle ops complete from here
// MUL   | shift-add multiply iterating, start_i ignored
module alu_exec_mc #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b0011;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] op_res;
  logic              op_ovf;
  logic              op_err;
  logic [DATA_W-1:0] acc_next;

  always_comb begin
    sum    = src1_i + src2_i;
    diff   = src1_i - src2_i;
    op_res = '0;
    op_ovf = 1'b0;
    op_err = 1'b0;
    case (ctrl_i)
      OP_AND: op_res = src1_i & src2_i;
      OP_OR:  op_res = src1_i | src2_i;
      OP_ADD: begin
        op_res = sum;
        op_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                 (sum[DATA_W-1] != src1_i[DATA_W-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                 (diff[DATA_W-1] != src1_i[DATA_W-1]);
      end
      OP_SLT: op_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default: op_err = 1'b1;
    endcase
  end

  // Accumulator value after the current iteration; also the final product
  // on the last iteration, so the result is written without an extra cycle.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (ctrl_i == OP_MUL) begin
              mcand  <= src1_i;
              mplier <= src2_i;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              result_o   <= op_res;
              zero_o     <= (op_res == '0);
              overflow_o <= op_ovf;
              err_o      <= op_err;
              done_o     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result_o   <= acc_next;
            zero_o     <= (acc_next == '0);
            overflow_o <= 1'b0;
            err_o      <= 1'b0;
            done_o     <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state == MUL);

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc. Expected values come from a
// behavioural model computed with wide signed arithmetic.
module tb_alu_exec_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   ctrl;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         err;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  alu_exec_mc #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .result_o(result), .zero_o(zero),
    .overflow_o(ovf), .err_o(err), .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {err, ovf, result} for one op, from the arithmetic definition
  function automatic logic [W+1:0] model(input logic [3:0] c,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, s;
    longint unsigned p;
    logic [W-1:0] r;
    logic o, e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 1'b0; e = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = W'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = W'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b0011: begin p = longint'(a) * longint'(b); r = W'(p); end
      default: e = 1'b1;
    endcase
    return {e, o, r};
  endfunction

  // completion view: {done, err, ovf, zero, result}
  function automatic logic [W+3:0] expect_done(input logic [W+1:0] m);
    return {1'b1, m[W+1], m[W], (m[W-1:0] == '0), m[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
    step(); step();
    checks++;
    if ({done, err, ovf, zero, busy, result} !== '0) begin
      errors++;
      $display("FAIL reset_init: got %h expected 0", {done, err, ovf, zero, busy, result});
    end
    rst = 1'b0;
    start = 1'b1; ctrl = 4'b0010; src1 = 32'h1234; src2 = 32'h1;
    step();
    start = 1'b1; ctrl = 4'b0011; src1 = 32'hdead; src2 = 32'hbeef;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({done, err, ovf, zero, busy, result} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {done, err, ovf, zero, busy, result});
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) begin
        checks++; errors++;
        $display("FAIL reset_no_done: cycle %0d done=%b busy=%b expected 0", i, done, busy);
        break;
      end
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]   c[5] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001};
    logic [W-1:0] a[5] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0};
    logic [W-1:0] b[5] = '{32'd1, 32'd5, 32'd1, 32'hFF00, 32'hFF00};
    logic [W+3:0] fixed[5] = '{{4'b1010, 32'h80000000}, {4'b1001, 32'h0},
                              {4'b1000, 32'h1}, {4'b1000, 32'hF000},
                              {4'b1000, 32'hFFF0}};
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; ctrl = c[i]; src1 = a[i]; src2 = b[i];
      step();
      checks++;
      if ({done, err, ovf, zero, result} !== fixed[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got %h expected %h", i, {done, err, ovf, zero, result}, fixed[i]);
      end
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || result !== 32'hFFF0) begin
      errors++;
      $display("FAIL b2b_tail: done=%b result=%h expected done=0 result=0000fff0", done, result);
    end
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      ctrl = c[$urandom_range(0, 4)];
      src1 = $urandom(); src2 = $urandom();
      if ($urandom_range(0, 3) == 0) src2 = src1;
      step();
      checks++;
      if ({done, err, ovf, zero, result} !== expect_done(model(ctrl, src1, src2))) begin
        errors++;
        $display("FAIL b2b_rand_%0d: ctrl=%b got %h expected %h", i, ctrl,
                 {done, err, ovf, zero, result}, expect_done(model(ctrl, src1, src2)));
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_mul();
    logic [W-1:0] a[6] = '{32'd7, 32'hFFFFFFFF, 32'h10000, 32'h0, 32'h0, 32'h0};
    logic [W-1:0] b[6] = '{32'd6, 32'd3, 32'h10000, 32'h0, 32'h0, 32'h0};
    logic [W-1:0] prev;
    int lat, busy_cnt;
    for (int i = 3; i < 6; i++) begin
      a[i] = $urandom(); b[i] = $urandom();
    end
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; ctrl = 4'b0011; src1 = a[i]; src2 = b[i];
      prev = result;
      step();
      start = 1'b0; src1 = $urandom(); src2 = $urandom();
      lat = 0; busy_cnt = 0;
      while (done !== 1'b1 && lat < 40) begin
        if (result !== prev) begin
          checks++; errors++;
          $display("FAIL mul_hold_%0d: result=%h expected %h", i, result, prev);
        end
        busy_cnt += (busy === 1'b1) ? 1 : 0;
        step();
        lat++;
      end
      checks++;
      if (lat != 32 || busy_cnt != 32) begin
        errors++;
        $display("FAIL mul_lat_%0d: latency=%0d busy=%0d expected 32/32", i, lat, busy_cnt);
      end
      checks++;
      if ({done, err, ovf, zero, result} !== expect_done(model(4'b0011, a[i], b[i])) || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_res_%0d: got %h busy=%b expected %h", i, {done, err, ovf, zero, result},
                 busy, expect_done(model(4'b0011, a[i], b[i])));
      end
      step();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mul_pulse_%0d: done=%b expected 0", i, done);
      end
    end
  endtask

  task automatic test_mul_ignored();
    logic [W-1:0] a = 32'h1234, b = 32'h56;
    int lat;
    start = 1'b1; ctrl = 4'b0011; src1 = a; src2 = b;
    step();
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start = (lat == 3 || lat == 17 || lat == 31) ? 1'b1 : 1'b0;
      ctrl = (lat == 17) ? 4'b0011 : 4'b0010;
      src1 = $urandom(); src2 = $urandom();
      step();
      lat++;
    end
    checks++;
    if (lat != 32 || {done, err, ovf, zero, result} !== expect_done(model(4'b0011, a, b))) begin
      errors++;
      $display("FAIL mul_ignored: lat=%0d got %h expected %h", lat, {done, err, ovf, zero, result},
               expect_done(model(4'b0011, a, b)));
    end
    start = 1'b1; ctrl = 4'b0010; src1 = 32'd10; src2 = 32'd20;
    step();
    start = 1'b0;
    checks++;
    if ({done, err, ovf, zero, result} !== {4'b1000, 32'd30} || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got %h busy=%b expected %h", {done, err, ovf, zero, result},
               busy, {4'b1000, 32'd30});
    end
    step();
  endtask

  task automatic test_unsupported();
    logic [3:0] bad[4] = '{4'b1111, 4'b0100, 4'b1001, 4'b0101};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; ctrl = bad[i]; src1 = $urandom() | 32'h1; src2 = $urandom();
      step();
      checks++;
      if ({done, err, ovf, zero, result} !== {4'b1101, 32'h0}) begin
        errors++;
        $display("FAIL unsup_%0d: got %h expected %h", i, {done, err, ovf, zero, result}, {4'b1101, 32'h0});
      end
    end
    start = 1'b1; ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd2;
    step();
    start = 1'b0;
    checks++;
    if ({done, err, ovf, zero, result} !== {4'b1000, 32'd3}) begin
      errors++;
      $display("FAIL unsup_clear: got %h expected %h", {done, err, ovf, zero, result}, {4'b1000, 32'd3});
    end
    step();
  endtask

  task automatic test_mul_reset();
    int lat;
    start = 1'b1; ctrl = 4'b0011; src1 = 32'hABCDEF; src2 = 32'h123;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, result} !== '0) begin
      errors++;
      $display("FAIL mul_abort: busy=%b done=%b result=%h expected 0", busy, done, result);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) begin
        checks++; errors++;
        $display("FAIL mul_abort_quiet: cycle %0d done=%b busy=%b expected 0", i, done, busy);
        break;
      end
    end
    start = 1'b1; ctrl = 4'b0011; src1 = 32'd3; src2 = 32'd4;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 32 || {done, err, ovf, zero, result} !== {4'b1000, 32'd12}) begin
      errors++;
      $display("FAIL mul_after_abort: lat=%0d got %h expected %h", lat,
               {done, err, ovf, zero, result}, {4'b1000, 32'd12});
    end
    step();
  endtask

  task automatic test_random_mix();
    logic [3:0] codes[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b1100};
    logic [W-1:0] a, b;
    logic [3:0] c;
    int lat;
    for (int i = 0; i < 30; i++) begin
      c = codes[$urandom_range(0, 6)];
      a = $urandom(); b = $urandom();
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      start = 1'b1; ctrl = c; src1 = a; src2 = b;
      step();
      start = 1'b0;
      lat = 0;
      if (c == 4'b0011) begin
        while (done !== 1'b1 && lat < 40) begin
          step();
          lat++;
        end
      end
      checks++;
      if ({done, err, ovf, zero, result} !== expect_done(model(c, a, b)) ||
          lat != ((c == 4'b0011) ? 32 : 0)) begin
        errors++;
        $display("FAIL rand_%0d: ctrl=%b lat=%0d got %h expected %h", i, c, lat,
                 {done, err, ovf, zero, result}, expect_done(model(c, a, b)));
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_mul_ignored();
    test_unsupported();
    test_mul_reset();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
